// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared binary32 constants and the itof state encoding
package float_pkg;

    localparam int FLT_BIAS   = 127;
    localparam int FLT_MANT_W = 23;
    localparam int FLT_EXP_W  = 8;

    // Exponent of a 32-bit magnitude whose MSB sits at bit 31 (127 + 31).
    localparam logic [8:0] FLT_EXP_INT = 9'd158;

    typedef enum logic [1:0] {
        ITOF_IDLE  = 2'd0,
        ITOF_NORM  = 2'd1,
        ITOF_ROUND = 2'd2,
        ITOF_HOLD  = 2'd3
    } itof_state_t;

endpackage

// File: rtl/float_round_rne.sv
// rtl/float_round_rne.sv - round-to-nearest-even of a normalised 32-bit significand
//
// Ports:
//   mag_i  - normalised magnitude, hidden bit at mag_i[31]
//   exp_i  - biased exponent belonging to mag_i (9 bits, never above 159)
//   res_o  - rounded {exp[7:0], mant[22:0]}
module float_round_rne
    import float_pkg::*;
(
    input  logic [31:0]                  mag_i,
    input  logic [8:0]                   exp_i,
    output logic [FLT_EXP_W+FLT_MANT_W-1:0] res_o
);

    logic        guard;
    logic        sticky;
    logic        inc;
    logic [24:0] sig;
    logic [8:0]  exp_r;

    always_comb begin
        guard  = mag_i[7];
        sticky = |mag_i[6:0];
        inc    = guard & (sticky | mag_i[8]);
        // Hidden bit included, so a mantissa overflow shows up in sig[24].
        sig    = {1'b0, mag_i[31:8]} + {24'd0, inc};
        exp_r  = exp_i + {8'd0, sig[24]};
        // On carry-out the significand is 1.000..., i.e. all-zero fraction.
        res_o  = {exp_r[7:0], sig[24] ? {FLT_MANT_W{1'b0}} : sig[22:0]};
    end

    // The exponent range 127..159 leaves bit 8 permanently clear.
    always_comb begin
        assert (exp_r[8] == 1'b0);
    end

endmodule

// File: rtl/float_itof.sv
// rtl/float_itof.sv - iterative int32/uint32 to binary32 converter
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake; in_ready only in IDLE outside reset
//   in_data, in_signed   - integer operand and its signedness
//   out_valid/out_ready  - output handshake; result held until accepted
//   out_data             - binary32 result
module float_itof
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    itof_state_t state_q;
    logic [31:0] mag_q;
    logic [8:0]  exp_q;
    logic        sign_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;

    logic        in_neg;
    logic [31:0] in_mag;
    logic [30:0] rounded;

    // Two's-complement negate maps -2^31 onto 0x8000_0000, which is the
    // correct unsigned magnitude, so no special case is needed.
    always_comb begin
        in_neg = in_signed & in_data[31];
        in_mag = in_neg ? (~in_data + 32'd1) : in_data;
    end

    float_round_rne u_round (
        .mag_i (mag_q),
        .exp_i (exp_q),
        .res_o (rounded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ITOF_IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ITOF_IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_neg;
                        mag_q  <= in_mag;
                        exp_q  <= FLT_EXP_INT;
                        if (in_mag == 32'd0) begin
                            out_data_q <= 32'h0000_0000;
                            state_q    <= ITOF_HOLD;
                        end else begin
                            state_q <= ITOF_NORM;
                        end
                    end
                end
                ITOF_NORM: begin
                    if (!mag_q[31]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 9'd1;
                    end else begin
                        state_q <= ITOF_ROUND;
                    end
                end
                ITOF_ROUND: begin
                    out_data_q  <= {sign_q, rounded};
                    out_valid_q <= 1'b1;
                    state_q     <= ITOF_HOLD;
                end
                ITOF_HOLD: begin
                    // The zero shortcut arrives here with out_valid still low;
                    // raising it one edge later keeps its latency at one cycle.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ITOF_IDLE;
                    end
                end
                default: state_q <= ITOF_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ITOF_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_float_itof.sv
// tb/tb_float_itof.sv - scoreboard bench for float_itof
module tb_float_itof;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    float_itof dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: exact integer arithmetic on the magnitude, then RNE on the
    // bits that fall below the 24-bit significand.
    function automatic logic [31:0] ref_itof(input logic [31:0] d, input logic sgn, output int k);
        longint unsigned m, q, rem, half;
        bit neg;
        int p, e, sh;
        neg = sgn && d[31];
        m = neg ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
        if (m == 0) begin
            k = -1;
            return 32'h0;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        k = 31 - p;
        e = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {neg, e[7:0], q[22:0]};
    endfunction

    task automatic convert(input logic [31:0] d, input logic s, input logic [31:0] expv, input int lat);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL in_ready_timeout: in_ready stuck low for %0d cycles", n);
            return;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk); #1;
        e.data = expv;
        e.lat  = lat;
        e.t    = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic convert_ref(input logic [31:0] d, input logic s);
        int k;
        logic [31:0] r;
        r = ref_itof(d, s, k);
        convert(d, s, r, (k < 0) ? 1 : k + 2);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    // Monitor: every rising out_valid must match the oldest expectation.
    initial begin
        bit prev = 1'b0;
        logic [31:0] held = '0;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_out_valid: out_data %h with nothing pending", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("result", out_data, e.data);
                        chk("latency", 32'(cyc - e.t), 32'(e.lat));
                    end
                    held = out_data;
                end else if (out_valid) begin
                    chk("hold_stable", out_data, held);
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    logic [31:0] dv [11] = '{32'd7, 32'hFFFF_FF85, 32'd1, 32'd0, 32'h8000_0000,
                             32'd16777217, 32'd16777219, 32'h7FFF_FFFF,
                             32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic        sv [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ev [11] = '{32'h40E0_0000, 32'hC2F6_0000, 32'h3F80_0000, 32'h0000_0000,
                             32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000,
                             32'h4F80_0000, 32'hCF00_0000, 32'hBF80_0000};
    int          lv [11] = '{31, 27, 33, 1, 2, 9, 9, 3, 2, 2, 33};

    initial begin
        logic [31:0] d;
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            convert(dv[i], sv[i], ev[i], lv[i]);
            drain();
        end

        // Abort mid-NORM on input 1.
        convert(32'd1, 1'b1, 32'h3F80_0000, 33);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        sb.delete();
        #1;
        chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("in_ready_post_rst", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_valid_after_abort", 32'(seen), 32'd0);
        convert(32'd5, 1'b0, 32'h40A0_0000, 31);
        drain();

        // Back-pressure: result held, new input ignored.
        out_ready = 1'b0;
        convert(32'd1000, 1'b0, 32'h447A_0000, 24);
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (10) begin
            in_valid = 1'b1; in_data = $urandom; in_signed = 1'b1;
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        convert(32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 31);
        drain();

        // Randomised phase with random output back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = $urandom >> $urandom_range(0, 31);
                2: d = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
                default: d = 32'($urandom_range(0, 255)) << $urandom_range(0, 24);
            endcase
            convert_ref(d, 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
